// File: rtl/reservation_station.sv
// reservation_station
//   Holds decoded ALU/branch/jump instructions until both source operands are
//   available, then issues one ready entry per cycle (lowest index first) to
//   the execute unit through a registered output stage. The execute and
//   load/store result buses are snooped to wake up waiting operands, including
//   operands arriving in the same cycle as their instruction is dispatched.
//
// Ports
//   clk_in, rst_n_in        clock (rising edge), asynchronous active-low reset
//   rdy_in                  0 = global stall, nothing changes, no issue
//   clr_in                  synchronous flush of every entry
//   disp_*_in               dispatch request and instruction fields
//   ex_cdb_*_in             execute result broadcast {en, tag, val}
//   lsb_cdb_*_in            load/store result broadcast {en, tag, val}
//   rs_full_out             every entry busy (from registered state)
//   rs_to_ex_en_out         one-cycle issue strobe
//   instr_id_out, imm_out, pc_out, rs1_out, rs2_out, rob_pos_out
//                           fields of the issued instruction (held when idle)
module reservation_station #(
    parameter int RS_SIZE    = 16,
    parameter int RS_IDX_W   = 4,
    parameter int ROB_IDX_W  = 4,
    parameter int INSTR_ID_W = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,
    input  logic                  disp_en_in,
    input  logic [INSTR_ID_W-1:0] disp_instr_id_in,
    input  logic [31:0]           disp_imm_in,
    input  logic [31:0]           disp_pc_in,
    input  logic [ROB_IDX_W-1:0]  disp_rob_pos_in,
    input  logic                  disp_rs1_rdy_in,
    input  logic [31:0]           disp_rs1_val_in,
    input  logic [ROB_IDX_W-1:0]  disp_rs1_tag_in,
    input  logic                  disp_rs2_rdy_in,
    input  logic [31:0]           disp_rs2_val_in,
    input  logic [ROB_IDX_W-1:0]  disp_rs2_tag_in,
    input  logic                  ex_cdb_en_in,
    input  logic [ROB_IDX_W-1:0]  ex_cdb_tag_in,
    input  logic [31:0]           ex_cdb_val_in,
    input  logic                  lsb_cdb_en_in,
    input  logic [ROB_IDX_W-1:0]  lsb_cdb_tag_in,
    input  logic [31:0]           lsb_cdb_val_in,
    output logic                  rs_full_out,
    output logic                  rs_to_ex_en_out,
    output logic [INSTR_ID_W-1:0] instr_id_out,
    output logic [31:0]           imm_out,
    output logic [31:0]           pc_out,
    output logic [31:0]           rs1_out,
    output logic [31:0]           rs2_out,
    output logic [ROB_IDX_W-1:0]  rob_pos_out
);

    logic [RS_SIZE-1:0]    busy;
    logic [INSTR_ID_W-1:0] e_id      [RS_SIZE];
    logic [31:0]           e_imm     [RS_SIZE];
    logic [31:0]           e_pc      [RS_SIZE];
    logic [ROB_IDX_W-1:0]  e_rob     [RS_SIZE];
    logic [RS_SIZE-1:0]    e_rs1_rdy;
    logic [31:0]           e_rs1_val [RS_SIZE];
    logic [ROB_IDX_W-1:0]  e_rs1_tag [RS_SIZE];
    logic [RS_SIZE-1:0]    e_rs2_rdy;
    logic [31:0]           e_rs2_val [RS_SIZE];
    logic [ROB_IDX_W-1:0]  e_rs2_tag [RS_SIZE];

    logic                  free_found;
    logic [RS_IDX_W-1:0]   free_idx;
    logic                  iss_vld_p0;
    logic [RS_IDX_W-1:0]   iss_idx_p0;
    logic                  disp_go;

    // Resolve one source operand against both result buses. Returns {rdy, val}.
    // Already-ready operands pass through; ex takes priority over lsb on a tie.
    function automatic logic [32:0] snoop(input logic                 rdy,
                                          input logic [31:0]          val,
                                          input logic [ROB_IDX_W-1:0] tag);
        if (rdy)
            return {1'b1, val};
        else if (ex_cdb_en_in && ex_cdb_tag_in == tag)
            return {1'b1, ex_cdb_val_in};
        else if (lsb_cdb_en_in && lsb_cdb_tag_in == tag)
            return {1'b1, lsb_cdb_val_in};
        else
            return {1'b0, val};
    endfunction

    assign rs_full_out = &busy;
    assign disp_go     = disp_en_in & rdy_in & ~clr_in & ~rs_full_out;

    // Stage p0: free-slot and issue selection from registered state.
    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        iss_vld_p0 = 1'b0;
        iss_idx_p0 = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_W'(i);
            end
            if (busy[i] && e_rs1_rdy[i] && e_rs2_rdy[i]) begin
                iss_vld_p0 = 1'b1;
                iss_idx_p0 = RS_IDX_W'(i);
            end
        end
    end

    // Entry payload and operand readiness; only meaningful while busy is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (disp_go && free_found && free_idx == RS_IDX_W'(i)) begin
                    e_id[i]  <= disp_instr_id_in;
                    e_imm[i] <= disp_imm_in;
                    e_pc[i]  <= disp_pc_in;
                    e_rob[i] <= disp_rob_pos_in;
                    e_rs1_tag[i] <= disp_rs1_tag_in;
                    e_rs2_tag[i] <= disp_rs2_tag_in;
                    {e_rs1_rdy[i], e_rs1_val[i]} <=
                        snoop(disp_rs1_rdy_in, disp_rs1_val_in, disp_rs1_tag_in);
                    {e_rs2_rdy[i], e_rs2_val[i]} <=
                        snoop(disp_rs2_rdy_in, disp_rs2_val_in, disp_rs2_tag_in);
                end else if (busy[i]) begin
                    {e_rs1_rdy[i], e_rs1_val[i]} <=
                        snoop(e_rs1_rdy[i], e_rs1_val[i], e_rs1_tag[i]);
                    {e_rs2_rdy[i], e_rs2_val[i]} <=
                        snoop(e_rs2_rdy[i], e_rs2_val[i], e_rs2_tag[i]);
                end
            end
        end
    end

    // Stage p1: busy bookkeeping and registered issue to execute.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy            <= '0;
            rs_to_ex_en_out <= 1'b0;
            instr_id_out    <= '0;
            imm_out         <= '0;
            pc_out          <= '0;
            rs1_out         <= '0;
            rs2_out         <= '0;
            rob_pos_out     <= '0;
        end else if (!rdy_in) begin
            rs_to_ex_en_out <= 1'b0;
        end else if (clr_in) begin
            busy            <= '0;
            rs_to_ex_en_out <= 1'b0;
        end else begin
            rs_to_ex_en_out <= iss_vld_p0;
            if (iss_vld_p0) begin
                busy[iss_idx_p0] <= 1'b0;
                instr_id_out     <= e_id[iss_idx_p0];
                imm_out          <= e_imm[iss_idx_p0];
                pc_out           <= e_pc[iss_idx_p0];
                rs1_out          <= e_rs1_val[iss_idx_p0];
                rs2_out          <= e_rs2_val[iss_idx_p0];
                rob_pos_out      <= e_rob[iss_idx_p0];
            end
            // The issued entry is busy, the dispatch target is not, so these
            // two writes never hit the same bit.
            if (disp_go && free_found)
                busy[free_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy, clr;
    logic        disp_en;
    logic [5:0]  disp_id;
    logic [31:0] disp_imm, disp_pc;
    logic [3:0]  disp_rob;
    logic        d_r1, d_r2;
    logic [31:0] d_v1, d_v2;
    logic [3:0]  d_t1, d_t2;
    logic        ex_en, lsb_en;
    logic [3:0]  ex_tag, lsb_tag;
    logic [31:0] ex_val, lsb_val;
    logic        full, en;
    logic [5:0]  id_o;
    logic [31:0] imm_o, pc_o, rs1_o, rs2_o;
    logic [3:0]  rob_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  rob;
    } item_t;

    item_t exp_q[$];

    reservation_station dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clr_in(clr),
        .disp_en_in(disp_en), .disp_instr_id_in(disp_id), .disp_imm_in(disp_imm),
        .disp_pc_in(disp_pc), .disp_rob_pos_in(disp_rob),
        .disp_rs1_rdy_in(d_r1), .disp_rs1_val_in(d_v1), .disp_rs1_tag_in(d_t1),
        .disp_rs2_rdy_in(d_r2), .disp_rs2_val_in(d_v2), .disp_rs2_tag_in(d_t2),
        .ex_cdb_en_in(ex_en), .ex_cdb_tag_in(ex_tag), .ex_cdb_val_in(ex_val),
        .lsb_cdb_en_in(lsb_en), .lsb_cdb_tag_in(lsb_tag), .lsb_cdb_val_in(lsb_val),
        .rs_full_out(full), .rs_to_ex_en_out(en), .instr_id_out(id_o),
        .imm_out(imm_o), .pc_out(pc_o), .rs1_out(rs1_o), .rs2_out(rs2_o),
        .rob_pos_out(rob_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every issue strobe is matched against the next expected item.
    always @(negedge clk) begin
        if (rst_n && en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got id %0h expected no issue", id_o);
            end else begin
                item_t e;
                e = exp_q.pop_front();
                chk("issue_fields", {id_o, imm_o, pc_o, rs1_o, rs2_o, rob_o}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] id, input logic [31:0] imm, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [3:0] rob);
        item_t e;
        e = '{id: id, imm: imm, pc: pc, rs1: rs1, rs2: rs2, rob: rob};
        exp_q.push_back(e);
    endtask

    task automatic disp(input logic [5:0] id, input logic [31:0] imm, input logic [31:0] pc,
                        input logic [3:0] rob,
                        input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [3:0] t2);
        disp_en = 1'b1; disp_id = id; disp_imm = imm; disp_pc = pc; disp_rob = rob;
        d_r1 = r1; d_v1 = v1; d_t1 = t1; d_r2 = r2; d_v2 = v2; d_t2 = t2;
        tick();
        disp_en = 1'b0;
    endtask

    task automatic ex_bcast(input logic [3:0] tag, input logic [31:0] val);
        ex_en = 1'b1; ex_tag = tag; ex_val = val;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; clr = 1'b0; disp_en = 1'b0;
        disp_id = '0; disp_imm = '0; disp_pc = '0; disp_rob = '0;
        d_r1 = 1'b0; d_v1 = '0; d_t1 = '0; d_r2 = 1'b0; d_v2 = '0; d_t2 = '0;
        ex_en = 1'b0; ex_tag = '0; ex_val = '0;
        lsb_en = 1'b0; lsb_tag = '0; lsb_val = '0;
        repeat (3) tick();
        chk("reset_outputs", {full, en, id_o, imm_o, pc_o, rs1_o, rs2_o, rob_o}, 0);
        rst_n = 1'b1;
        tick();

        // ADDI: both sources ready, two edges to issue, one-cycle strobe
        push(6'd1, 32'd7, 32'h100, 32'd5, 32'd0, 4'd3);
        disp(6'd1, 32'd7, 32'h100, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0);
        chk("t1_en_after_disp", en, 0);
        tick();
        chk("t1_en_issue", en, 1);
        tick();
        chk("t1_en_drop", en, 0);

        // ADD waiting on tag 2, woken by ex bus
        push(6'd2, 32'd0, 32'h104, 32'h10, 32'h22, 4'd4);
        disp(6'd2, 32'd0, 32'h104, 4'd4, 1'b0, 32'd0, 4'd2, 1'b1, 32'h22, 4'd0);
        tick();
        chk("t2_waiting", en, 0);
        ex_bcast(4'd2, 32'h10);
        tick();
        ex_en = 1'b0;
        chk("t2_wake_cycle", en, 0);
        tick();
        chk("t2_issue", en, 1);

        // Same-cycle bypass from lsb bus on rs2
        lsb_en = 1'b1; lsb_tag = 4'd7; lsb_val = 32'hABCD;
        push(6'd3, 32'd1, 32'h108, 32'h31, 32'hABCD, 4'd5);
        disp(6'd3, 32'd1, 32'h108, 4'd5, 1'b1, 32'h31, 4'd0, 1'b0, 32'd0, 4'd7);
        lsb_en = 1'b0;
        chk("t3_en_after_disp", en, 0);
        tick();
        chk("t3_bypass_issue", en, 1);
        wait_drain("t3_drain");

        // Fill all 16 entries, each waiting on rs1 tag k
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("t4_not_full_at_15", full, 0);
            disp(6'(20 + k), 32'(k), 32'h1000 + 32'(4 * k), 4'(k),
                 1'b0, 32'd0, 4'(k), 1'b1, 32'h200 + 32'(k), 4'd0);
        end
        chk("t4_full", full, 1);
        disp(6'd63, 32'd0, 32'd0, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        chk("t4_17th_ignored_full", full, 1);
        ex_bcast(4'd5, 32'h5005);
        push(6'd25, 32'd5, 32'h1014, 32'h5005, 32'h205, 4'd5);
        tick();
        ex_en = 1'b0;
        chk("t4_full_before_issue", full, 1);
        tick();
        chk("t4_one_issue", en, 1);
        chk("t4_not_full_after_issue", full, 0);
        for (int k = 0; k < 16; k++) begin
            if (k != 5) begin
                ex_bcast(4'(k), 32'h5000 + 32'(k));
                if (k == 9) begin
                    lsb_en = 1'b1; lsb_tag = 4'd9; lsb_val = 32'hDEAD;
                end
                push(6'(20 + k), 32'(k), 32'h1000 + 32'(4 * k), 32'h5000 + 32'(k),
                     32'h200 + 32'(k), 4'(k));
                tick();
                ex_en = 1'b0;
                lsb_en = 1'b0;
            end
        end
        wait_drain("t4_drain");

        // Entries 1 and 4 become ready together; lowest index first
        disp(6'd30, 32'd0, 32'h300, 4'd0, 1'b0, 32'd0, 4'd10, 1'b1, 32'd0, 4'd0);
        disp(6'd31, 32'd0, 32'h304, 4'd1, 1'b0, 32'd0, 4'd11, 1'b1, 32'h31, 4'd0);
        disp(6'd32, 32'd0, 32'h308, 4'd2, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0);
        disp(6'd33, 32'd0, 32'h30C, 4'd3, 1'b0, 32'd0, 4'd13, 1'b1, 32'd0, 4'd0);
        disp(6'd34, 32'd0, 32'h310, 4'd4, 1'b1, 32'h44, 4'd0, 1'b0, 32'd0, 4'd11);
        push(6'd31, 32'd0, 32'h304, 32'hBB, 32'h31, 4'd1);
        push(6'd34, 32'd0, 32'h310, 32'h44, 32'hBB, 4'd4);
        ex_bcast(4'd11, 32'hBB);
        tick();
        ex_en = 1'b0;
        chk("t5_wake_cycle", en, 0);
        tick();
        chk("t5_first_issue", en, 1);
        tick();
        chk("t5_second_issue", en, 1);
        tick();
        chk("t5_idle", en, 0);

        // Flush with 5 busy entries; dispatch in the flush cycle is dropped
        disp(6'd35, 32'd0, 32'h320, 4'd6, 1'b0, 32'd0, 4'd14, 1'b1, 32'd0, 4'd0);
        disp(6'd36, 32'd0, 32'h324, 4'd7, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0);
        clr = 1'b1;
        disp(6'd60, 32'd0, 32'h400, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        clr = 1'b0;
        chk("t6_clr_en", en, 0);
        chk("t6_clr_full", full, 0);
        for (int k = 10; k < 16; k++) begin
            ex_bcast(4'(k), 32'h77);
            tick();
        end
        ex_en = 1'b0;
        repeat (3) tick();
        chk("t6_no_issue_after_clr", en, 0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("t6_all_entries_free", full, 0);
            disp(6'd50, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        end
        chk("t6_refill_full", full, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t6_clr_empty", full, 0);

        // Stall: 3 cycles with a ready entry, broadcast during stall not captured
        disp(6'd41, 32'd0, 32'h500, 4'd9, 1'b0, 32'd0, 4'd6, 1'b1, 32'd0, 4'd0);
        push(6'd40, 32'd2, 32'h504, 32'h4040, 32'd0, 4'd8);
        disp(6'd40, 32'd2, 32'h504, 4'd8, 1'b1, 32'h4040, 4'd0, 1'b1, 32'd0, 4'd0);
        rdy = 1'b0;
        ex_bcast(4'd6, 32'h66);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_stall_no_issue", en, 0);
        end
        rdy = 1'b1;
        ex_en = 1'b0;
        tick();
        chk("t6_issue_after_stall", en, 1);
        tick();
        chk("t6_stall_idle", en, 0);
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Asynchronous reset while an issue is on the outputs
        push(6'd52, 32'h9, 32'h600, 32'h52, 32'h53, 4'd2);
        disp(6'd52, 32'h9, 32'h600, 4'd2, 1'b1, 32'h52, 4'd0, 1'b1, 32'h53, 4'd0);
        tick();
        chk("rst_pre_issue", en, 1);
        #6;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {full, en, id_o, imm_o, pc_o, rs1_o, rs2_o, rob_o}, 0);
        #1;
        rst_n = 1'b1;
        tick();
        push(6'd53, 32'h1, 32'h604, 32'h3, 32'h4, 4'd1);
        disp(6'd53, 32'h1, 32'h604, 4'd1, 1'b1, 32'h3, 4'd0, 1'b1, 32'h4, 4'd0);
        tick();
        chk("post_reset_issue", en, 1);
        wait_drain("final_drain");
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
